// File: rtl/load_store_queue.sv
// load_store_queue: circular in-order load/store queue between dispatch,
// ROB commit, the data cache and NUM_WB result broadcast channels.
// Ports: clockIn/resetIn(async, low)/clearIn(flush)/readyIn(enable);
//   wbValid/wbRobIndex/wbVal broadcasts; robBeginId/robBeginValid commit;
//   add* dispatch entry; full/occupancy status; mem* cache request and
//   response; lsbUpdate/lsbRobIndex/lsbUpdateVal load result broadcast.
module load_store_queue #(
   parameter int ROB_WIDTH    = 4,
   parameter int LSB_WIDTH    = 4,
   parameter int LSB_OP_WIDTH = 3,
   parameter int NUM_WB       = 2,
   parameter int FULL_MARGIN  = 3
) (
   input  logic                          clockIn,
   input  logic                          resetIn,
   input  logic                          clearIn,
   input  logic                          readyIn,
   input  logic [NUM_WB-1:0]             wbValid,
   input  logic [NUM_WB*ROB_WIDTH-1:0]   wbRobIndex,
   input  logic [NUM_WB*32-1:0]          wbVal,
   input  logic [ROB_WIDTH-1:0]          robBeginId,
   input  logic                          robBeginValid,
   input  logic                          addValid,
   input  logic                          addReadWrite,
   input  logic [ROB_WIDTH-1:0]          addRobId,
   input  logic                          addBaseHasDep,
   input  logic [31:0]                   addBase,
   input  logic [ROB_WIDTH-1:0]          addBaseConstrtId,
   input  logic [31:0]                   addOffset,
   input  logic                          addDataHasDep,
   input  logic [31:0]                   addData,
   input  logic [ROB_WIDTH-1:0]          addDataConstrtId,
   input  logic [LSB_OP_WIDTH-1:0]       addOp,
   output logic                          full,
   output logic [LSB_WIDTH:0]            occupancy,
   output logic [1:0]                    memAccessType,
   output logic                          memReadWrite,
   output logic [31:0]                   memAddr,
   output logic [31:0]                   memDataOut,
   input  logic                          memDataValid,
   input  logic [31:0]                   memDataIn,
   input  logic                          memWriteSuc,
   output logic                          lsbUpdate,
   output logic [ROB_WIDTH-1:0]          lsbRobIndex,
   output logic [31:0]                   lsbUpdateVal
);

   localparam int LSB_SIZE = 2 ** LSB_WIDTH;
   localparam logic [LSB_WIDTH:0] CAP = (LSB_WIDTH+1)'(LSB_SIZE);
   localparam logic [LSB_WIDTH:0] FULL_AT =
      (LSB_WIDTH+1)'(LSB_SIZE - FULL_MARGIN);

   localparam logic [LSB_OP_WIDTH-1:0] OP_B  = LSB_OP_WIDTH'(0);
   localparam logic [LSB_OP_WIDTH-1:0] OP_H  = LSB_OP_WIDTH'(1);
   localparam logic [LSB_OP_WIDTH-1:0] OP_BU = LSB_OP_WIDTH'(3);
   localparam logic [LSB_OP_WIDTH-1:0] OP_HU = LSB_OP_WIDTH'(4);

   typedef struct packed {
      logic                    valid;
      logic                    is_load;
      logic                    committed;
      logic [ROB_WIDTH-1:0]    rob_id;
      logic                    base_rdy;
      logic [ROB_WIDTH-1:0]    base_tag;
      logic [31:0]             base;
      logic [31:0]             offset;
      logic                    data_rdy;
      logic [ROB_WIDTH-1:0]    data_tag;
      logic [31:0]             data;
      logic [LSB_OP_WIDTH-1:0] op;
   } ent_t;

   typedef enum logic [1:0] {P_NONE, P_LD, P_ST} pend_e;

   function automatic logic [1:0] size_of(input logic [LSB_OP_WIDTH-1:0] op);
      logic [1:0] s;
      unique case (1'b1)
         (op == OP_B) || (op == OP_BU): s = 2'b01;
         (op == OP_H) || (op == OP_HU): s = 2'b10;
         default:                       s = 2'b11;
      endcase
      return s;
   endfunction

   function automatic logic [31:0] mask(input logic [31:0] d,
                                        input logic [1:0] sz);
      logic [31:0] r;
      unique case (1'b1)
         sz == 2'b01: r = {24'h0, d[7:0]};
         sz == 2'b10: r = {16'h0, d[15:0]};
         default:     r = d;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] ext(input logic [LSB_OP_WIDTH-1:0] op,
                                       input logic [31:0] d);
      logic [31:0] r;
      unique case (1'b1)
         op == OP_B:  r = {{24{d[7]}}, d[7:0]};
         op == OP_H:  r = {{16{d[15]}}, d[15:0]};
         op == OP_BU: r = {24'h0, d[7:0]};
         op == OP_HU: r = {16'h0, d[15:0]};
         default:     r = d;
      endcase
      return r;
   endfunction

   // {hit, value}; own channel first so any external channel overrides it,
   // and channels walked high to low so channel 0 wins.
   function automatic logic [32:0] lookup(
      input logic [ROB_WIDTH-1:0]        tag,
      input logic [NUM_WB-1:0]           v,
      input logic [NUM_WB*ROB_WIDTH-1:0] ids,
      input logic [NUM_WB*32-1:0]        vals,
      input logic                        ov,
      input logic [ROB_WIDTH-1:0]        oid,
      input logic [31:0]                 oval
   );
      logic [32:0] r;
      r = '0;
      if (ov && oid == tag) r = {1'b1, oval};
      for (int k = NUM_WB - 1; k >= 0; k--) begin
         if (v[k] && ids[k*ROB_WIDTH +: ROB_WIDTH] == tag)
            r = {1'b1, vals[k*32 +: 32]};
      end
      return r;
   endfunction

   ent_t                    ent_q [LSB_SIZE];
   ent_t                    ent_d [LSB_SIZE];
   logic [LSB_WIDTH-1:0]    head_q, head_d, tail_q, tail_d;
   logic [LSB_WIDTH:0]      count_q, count_d;
   pend_e                   pend_q, pend_d;
   logic [ROB_WIDTH-1:0]    pend_rob_q, pend_rob_d;
   logic [LSB_OP_WIDTH-1:0] pend_op_q, pend_op_d;
   logic                    kill_q, kill_d;
   logic                    fwd_valid_q, fwd_valid_d;
   logic [31:0]             fwd_addr_q, fwd_addr_d;
   logic [1:0]              fwd_size_q, fwd_size_d;
   logic [31:0]             fwd_data_q, fwd_data_d;
   logic                    upd_q, upd_d;
   logic [ROB_WIDTH-1:0]    upd_rob_q, upd_rob_d;
   logic [31:0]             upd_val_q, upd_val_d;
   logic [1:0]              mem_type_q, mem_type_d;
   logic                    mem_rw_q, mem_rw_d;
   logic [31:0]             mem_addr_q, mem_addr_d;
   logic [31:0]             mem_wdata_q, mem_wdata_d;

   logic        resp_ld, resp_now, can_go, upd_mem;
   logic [31:0] h_addr;
   logic [1:0]  h_size;
   logic        h_io, h_cm, h_ok, fwd_hit, pop, do_add;
   logic [32:0] lk_b, lk_d;
   ent_t        nw;

   assign resp_ld  = readyIn & (pend_q == P_LD) & memDataValid;
   assign resp_now = resp_ld | (readyIn & (pend_q == P_ST) & memWriteSuc);
   assign can_go   = (pend_q == P_NONE) | resp_now;
   // A flushed load's response is swallowed here.
   assign upd_mem  = resp_ld & ~kill_q & ~clearIn;

   assign lsbUpdate    = upd_mem | upd_q;
   assign lsbRobIndex  = upd_mem ? pend_rob_q : upd_rob_q;
   assign lsbUpdateVal = upd_mem ? ext(pend_op_q, memDataIn) :
                         (upd_q ? upd_val_q : 32'h0);

   assign full          = (count_q >= FULL_AT);
   assign occupancy     = count_q;
   assign memAccessType = mem_type_q;
   assign memReadWrite  = mem_rw_q;
   assign memAddr       = mem_addr_q;
   assign memDataOut    = mem_wdata_q;

   always_comb begin
      ent_d       = ent_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      pend_d      = pend_q;
      pend_rob_d  = pend_rob_q;
      pend_op_d   = pend_op_q;
      kill_d      = kill_q;
      fwd_valid_d = fwd_valid_q;
      fwd_addr_d  = fwd_addr_q;
      fwd_size_d  = fwd_size_q;
      fwd_data_d  = fwd_data_q;
      upd_d       = upd_q;
      upd_rob_d   = upd_rob_q;
      upd_val_d   = upd_val_q;
      mem_type_d  = mem_type_q;
      mem_rw_d    = mem_rw_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      pop         = 1'b0;
      do_add      = 1'b0;
      lk_b        = '0;
      lk_d        = '0;
      nw          = '0;

      h_addr  = ent_q[head_q].base + ent_q[head_q].offset;
      h_size  = size_of(ent_q[head_q].op);
      h_io    = (h_addr[17:16] == 2'b11);
      // Commit arriving this cycle counts, so the entry may issue at once.
      h_cm    = ent_q[head_q].committed |
                (robBeginValid & (robBeginId == ent_q[head_q].rob_id));
      h_ok    = ent_q[head_q].base_rdy &
                (ent_q[head_q].is_load ? (~h_io | h_cm) :
                 (h_cm & ent_q[head_q].data_rdy));
      fwd_hit = ent_q[head_q].is_load & ~h_io & fwd_valid_q &
                (fwd_addr_q == h_addr) & (fwd_size_q == h_size);

      if (readyIn) begin
         mem_type_d = 2'b00;
         upd_d      = 1'b0;
         if (resp_now) pend_d = P_NONE;

         for (int i = 0; i < LSB_SIZE; i++) begin
            if (ent_q[i].valid) begin
               if (!ent_q[i].base_rdy) begin
                  lk_b = lookup(ent_q[i].base_tag, wbValid, wbRobIndex,
                                wbVal, lsbUpdate, lsbRobIndex, lsbUpdateVal);
                  if (lk_b[32]) begin
                     ent_d[i].base_rdy = 1'b1;
                     ent_d[i].base     = lk_b[31:0];
                  end
               end
               if (!ent_q[i].data_rdy) begin
                  lk_d = lookup(ent_q[i].data_tag, wbValid, wbRobIndex,
                                wbVal, lsbUpdate, lsbRobIndex, lsbUpdateVal);
                  if (lk_d[32]) begin
                     ent_d[i].data_rdy = 1'b1;
                     ent_d[i].data     = lk_d[31:0];
                  end
               end
               if (robBeginValid && robBeginId == ent_q[i].rob_id)
                  ent_d[i].committed = 1'b1;
            end
         end

         if (clearIn) begin
            for (int i = 0; i < LSB_SIZE; i++) begin
               if (!ent_d[i].committed) ent_d[i].valid = 1'b0;
            end
            if (pend_q == P_LD) kill_d = 1'b1;
         end else begin
            if (count_q != '0) begin
               if (!ent_q[head_q].valid) begin
                  pop = 1'b1;
               end else if (h_ok && can_go) begin
                  pop = 1'b1;
                  if (fwd_hit) begin
                     upd_d     = 1'b1;
                     upd_rob_d = ent_q[head_q].rob_id;
                     upd_val_d = ext(ent_q[head_q].op, fwd_data_q);
                  end else begin
                     mem_type_d = h_size;
                     mem_rw_d   = ent_q[head_q].is_load;
                     mem_addr_d = h_addr;
                     pend_d     = ent_q[head_q].is_load ? P_LD : P_ST;
                     pend_rob_d = ent_q[head_q].rob_id;
                     pend_op_d  = ent_q[head_q].op;
                     kill_d     = 1'b0;
                     if (!ent_q[head_q].is_load) begin
                        mem_wdata_d = mask(ent_q[head_q].data, h_size);
                        fwd_valid_d = 1'b1;
                        fwd_addr_d  = h_addr;
                        fwd_size_d  = h_size;
                        fwd_data_d  = mask(ent_q[head_q].data, h_size);
                     end
                  end
               end
            end
            if (pop) begin
               ent_d[head_q].valid = 1'b0;
               head_d = head_q + LSB_WIDTH'(1);
            end

            if (addValid && count_q != CAP) begin
               lk_b = lookup(addBaseConstrtId, wbValid, wbRobIndex, wbVal,
                             lsbUpdate, lsbRobIndex, lsbUpdateVal);
               lk_d = lookup(addDataConstrtId, wbValid, wbRobIndex, wbVal,
                             lsbUpdate, lsbRobIndex, lsbUpdateVal);
               nw.valid     = 1'b1;
               nw.is_load   = addReadWrite;
               nw.committed = robBeginValid & (robBeginId == addRobId);
               nw.rob_id    = addRobId;
               nw.base_tag  = addBaseConstrtId;
               nw.base_rdy  = ~addBaseHasDep | lk_b[32];
               nw.base      = addBaseHasDep ? lk_b[31:0] : addBase;
               nw.offset    = addOffset;
               nw.data_tag  = addDataConstrtId;
               nw.data_rdy  = ~addDataHasDep | lk_d[32];
               nw.data      = addDataHasDep ? lk_d[31:0] : addData;
               nw.op        = addOp;
               ent_d[tail_q] = nw;
               tail_d = tail_q + LSB_WIDTH'(1);
               do_add = 1'b1;
            end
            count_d = count_q + {{LSB_WIDTH{1'b0}}, do_add}
                              - {{LSB_WIDTH{1'b0}}, pop};
         end
      end
   end

   always_ff @(posedge clockIn or negedge resetIn) begin
      if (!resetIn) begin
         for (int i = 0; i < LSB_SIZE; i++) ent_q[i] <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         pend_q      <= P_NONE;
         pend_rob_q  <= '0;
         pend_op_q   <= '0;
         kill_q      <= 1'b0;
         fwd_valid_q <= 1'b0;
         fwd_addr_q  <= '0;
         fwd_size_q  <= '0;
         fwd_data_q  <= '0;
         upd_q       <= 1'b0;
         upd_rob_q   <= '0;
         upd_val_q   <= '0;
         mem_type_q  <= 2'b00;
         mem_rw_q    <= 1'b1;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         for (int i = 0; i < LSB_SIZE; i++) ent_q[i] <= ent_d[i];
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         pend_q      <= pend_d;
         pend_rob_q  <= pend_rob_d;
         pend_op_q   <= pend_op_d;
         kill_q      <= kill_d;
         fwd_valid_q <= fwd_valid_d;
         fwd_addr_q  <= fwd_addr_d;
         fwd_size_q  <= fwd_size_d;
         fwd_data_q  <= fwd_data_d;
         upd_q       <= upd_d;
         upd_rob_q   <= upd_rob_d;
         upd_val_q   <= upd_val_d;
         mem_type_q  <= mem_type_d;
         mem_rw_q    <= mem_rw_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

endmodule
